// File: rtl/xadac_pkg.sv
// Shared types and constants for xadac link endpoints.
// Request/response payloads and the dot-product execute state encoding.
package xadac_pkg;

    localparam int XadacXlen = 32;
    localparam int IdW = 4;
    localparam logic [6:0] DotOpcode = 7'b0001011;

    typedef struct packed {
        logic [IdW-1:0] id;
        logic [31:0]    instr;
    } DecReqT;

    typedef struct packed {
        logic [IdW-1:0] id;
        logic           accept;
        logic           writeback;
    } DecRspT;

    typedef struct packed {
        logic [IdW-1:0]       id;
        logic [XadacXlen-1:0] rs1;
        logic [XadacXlen-1:0] rs2;
    } ExeReqT;

    typedef struct packed {
        logic [IdW-1:0]       id;
        logic [XadacXlen-1:0] data;
        logic                 err;
    } ExeRspT;

    typedef enum logic [1:0] {
        ExeIdle = 2'd0,
        ExeBusy = 2'd1,
        ExeDone = 2'd2
    } exe_state_e;

endpackage

// File: rtl/xadac_if.sv
// xadac link: decode and execute channels, each a request/response pair.
// dbg_state is driven by the slave so checkers can observe its execute FSM.
interface xadac_if;
    import xadac_pkg::*;

    // Handshake: a transfer happens on a rising clk edge where valid && ready.
    // Once valid is high it stays high with a stable payload until that edge;
    // valid never depends combinationally on its own ready.
    logic       dec_req_valid;
    logic       dec_req_ready;
    DecReqT     dec_req;
    logic       dec_rsp_valid;
    logic       dec_rsp_ready;
    DecRspT     dec_rsp;
    logic       exe_req_valid;
    logic       exe_req_ready;
    ExeReqT     exe_req;
    logic       exe_rsp_valid;
    logic       exe_rsp_ready;
    ExeRspT     exe_rsp;
    exe_state_e dbg_state;

    modport mst (
        output dec_req_valid, dec_req, dec_rsp_ready,
        output exe_req_valid, exe_req, exe_rsp_ready,
        input  dec_req_ready, dec_rsp_valid, dec_rsp,
        input  exe_req_ready, exe_rsp_valid, exe_rsp, dbg_state
    );

    modport slv (
        input  dec_req_valid, dec_req, dec_rsp_ready,
        input  exe_req_valid, exe_req, exe_rsp_ready,
        output dec_req_ready, dec_rsp_valid, dec_rsp,
        output exe_req_ready, exe_rsp_valid, exe_rsp, dbg_state
    );

endinterface

// File: rtl/xadac_dot_core.sv
// Lane-serial multiply-accumulate datapath for the dot-product unit.
// Operands shift down one lane per step so lane 0 always feeds the multiplier.
module xadac_dot_core
    import xadac_pkg::*;
#(
    parameter int LaneW  = 8,
    parameter bit Signed = 1'b1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic                 step,
    input  logic [IdW-1:0]       id,
    input  logic [XadacXlen-1:0] rs1,
    input  logic [XadacXlen-1:0] rs2,
    output logic                 last,
    output logic [IdW-1:0]       id_q,
    output logic [XadacXlen-1:0] data
);
    localparam int NumLanes = XadacXlen / LaneW;
    localparam int CntW     = (NumLanes > 1) ? $clog2(NumLanes) : 1;
    localparam int AccW     = 2 * LaneW + $clog2(NumLanes);

    logic [XadacXlen-1:0] rs1_q, rs2_q;
    logic [CntW-1:0]      cnt_q;
    logic [AccW-1:0]      acc_q;
    logic [AccW-1:0]      prod;

    // Extending both lanes to the accumulator width before multiplying keeps
    // the low AccW bits of the product exact for either signedness.
    function automatic logic [AccW-1:0] ext(input logic [LaneW-1:0] v);
        return {{(AccW - LaneW){Signed & v[LaneW-1]}}, v};
    endfunction

    assign prod = ext(rs1_q[LaneW-1:0]) * ext(rs2_q[LaneW-1:0]);
    assign last = (cnt_q == CntW'(NumLanes - 1));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rs1_q <= '0;
            rs2_q <= '0;
            id_q  <= '0;
            cnt_q <= '0;
            acc_q <= '0;
        end else if (start) begin
            rs1_q <= rs1;
            rs2_q <= rs2;
            id_q  <= id;
            cnt_q <= '0;
            acc_q <= '0;
        end else if (step) begin
            rs1_q <= rs1_q >> LaneW;
            rs2_q <= rs2_q >> LaneW;
            cnt_q <= cnt_q + 1'b1;
            acc_q <= acc_q + prod;
        end
    end

    if (AccW >= XadacXlen) begin : g_trunc
        assign data = acc_q[XadacXlen-1:0];
    end else begin : g_ext
        assign data = {{(XadacXlen - AccW){Signed & acc_q[AccW-1]}}, acc_q};
    end

endmodule

// File: rtl/xadac_dot.sv
// xadac slave endpoint decoding and executing `dot rd, rs1, rs2`.
// Decode is a one-entry response register; execute is an IDLE/BUSY/DONE FSM.
module xadac_dot
    import xadac_pkg::*;
#(
    parameter int         LaneW  = 8,
    parameter bit         Signed = 1'b1,
    parameter logic [6:0] Funct7 = 7'b0000000,
    parameter logic [2:0] Funct3 = 3'b000
) (
    input logic   clk,
    input logic   rstn,
    xadac_if.slv  slv
);
    logic   dec_req_ready;
    logic   dec_fire;
    logic   dec_accept;
    logic   dec_rsp_valid_q;
    DecRspT dec_rsp_q;

    assign dec_req_ready = !dec_rsp_valid_q || slv.dec_rsp_ready;
    assign dec_fire      = slv.dec_req_valid && dec_req_ready;
    assign dec_accept    = (slv.dec_req.instr[6:0] == DotOpcode)
                        && (slv.dec_req.instr[14:12] == Funct3)
                        && (slv.dec_req.instr[31:25] == Funct7);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            dec_rsp_valid_q <= 1'b0;
            dec_rsp_q       <= '0;
        end else if (dec_fire) begin
            dec_rsp_valid_q     <= 1'b1;
            dec_rsp_q.id        <= slv.dec_req.id;
            dec_rsp_q.accept    <= dec_accept;
            dec_rsp_q.writeback <= 1'b0;
        end else if (slv.dec_rsp_ready) begin
            dec_rsp_valid_q <= 1'b0;
        end
    end

    assign slv.dec_req_ready = dec_req_ready;
    assign slv.dec_rsp_valid = dec_rsp_valid_q;
    assign slv.dec_rsp       = dec_rsp_q;

    exe_state_e           state_q, state_d;
    logic                 core_start, core_step, core_last;
    logic [IdW-1:0]       core_id;
    logic [XadacXlen-1:0] core_data;

    always_ff @(posedge clk) begin
        if (!rstn) state_q <= ExeIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        core_start = 1'b0;
        core_step  = 1'b0;
        unique case (state_q)
            ExeIdle: if (slv.exe_req_valid) begin
                core_start = 1'b1;
                state_d    = ExeBusy;
            end
            ExeBusy: begin
                core_step = 1'b1;
                if (core_last) state_d = ExeDone;
            end
            ExeDone: if (slv.exe_rsp_ready) state_d = ExeIdle;
            default: state_d = ExeIdle;
        endcase
    end

    xadac_dot_core #(
        .LaneW  (LaneW),
        .Signed (Signed)
    ) u_core (
        .clk   (clk),
        .rstn  (rstn),
        .start (core_start),
        .step  (core_step),
        .id    (slv.exe_req.id),
        .rs1   (slv.exe_req.rs1),
        .rs2   (slv.exe_req.rs2),
        .last  (core_last),
        .id_q  (core_id),
        .data  (core_data)
    );

    // Readiness and response valid come from the state register alone.
    assign slv.exe_req_ready = (state_q == ExeIdle);
    assign slv.exe_rsp_valid = (state_q == ExeDone);
    assign slv.exe_rsp       = ExeRspT'{id: core_id, data: core_data, err: 1'b0};
    assign slv.dbg_state     = state_q;

endmodule

// File: tb/tb_xadac_dot.sv
// Bench for xadac_dot: a signed and an unsigned instance share all stimulus;
// results are scored against a lane-by-lane arithmetic model.
module tb_xadac_dot;
    import xadac_pkg::*;

    localparam int NumLanes = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   cyc = 0;
    int   hs_cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    logic [IdW+31:0] exp_s_q[$];
    logic [IdW+31:0] exp_u_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    xadac_if ifs ();
    xadac_if ifu ();

    xadac_dot #(.LaneW(8), .Signed(1'b1)) u_dut_s (.clk(clk), .rstn(rstn), .slv(ifs.slv));
    xadac_dot #(.LaneW(8), .Signed(1'b0)) u_dut_u (.clk(clk), .rstn(rstn), .slv(ifu.slv));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dot_ref(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        int sum;
        int xa;
        int xb;
        sum = 0;
        for (int i = 0; i < 4; i++) begin
            xa = sgn ? int'($signed(a[8*i +: 8])) : int'(a[8*i +: 8]);
            xb = sgn ? int'($signed(b[8*i +: 8])) : int'(b[8*i +: 8]);
            sum += xa * xb;
        end
        return 32'(sum);
    endfunction

    function automatic logic dec_ref(input logic [31:0] instr);
        return (instr[6:0] == 7'h0B) && (instr[14:12] == 3'b000) && (instr[31:25] == 7'h00);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0: begin r[6:0] = 7'h0B; r[14:12] = 3'b000; r[31:25] = 7'h00; end
            1: begin r[6:0] = 7'h0B; r[31:25] = 7'h00; end
            2: begin r[6:0] = 7'h0B; r[14:12] = 3'b000; end
            default: ;
        endcase
        return r;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic dec_set(input logic v, input logic [IdW-1:0] did, input logic [31:0] instr);
        ifs.dec_req_valid = v;
        ifu.dec_req_valid = v;
        ifs.dec_req = '{id: did, instr: instr};
        ifu.dec_req = '{id: did, instr: instr};
    endtask

    task automatic dec_check(input logic [IdW-1:0] did, input logic [31:0] instr);
        check("dec_rsp_valid", 64'(ifs.dec_rsp_valid), 64'(1));
        check("dec_rsp", 64'({ifs.dec_rsp.id, ifs.dec_rsp.accept, ifs.dec_rsp.writeback}),
              64'({did, dec_ref(instr), 1'b0}));
        check("dec_rsp_u", 64'({ifu.dec_rsp_valid, ifu.dec_rsp.id, ifu.dec_rsp.accept}),
              64'({1'b1, did, dec_ref(instr)}));
    endtask

    // Streams one decode request; the caller deasserts valid when done.
    task automatic dec_drive(input logic [IdW-1:0] did, input logic [31:0] instr);
        dec_set(1'b1, did, instr);
        check("dec_req_ready", 64'(ifs.dec_req_ready), 64'(1));
        cycle();
        dec_check(did, instr);
    endtask

    task automatic dec_stop();
        dec_set(1'b0, '0, '0);
        cycle();
        check("dec_rsp_drop", 64'({ifs.dec_rsp_valid, ifu.dec_rsp_valid}), 64'(0));
    endtask

    task automatic exe_set(input logic v, input logic [IdW-1:0] tid, input logic [31:0] a, input logic [31:0] b);
        ifs.exe_req_valid = v;
        ifu.exe_req_valid = v;
        ifs.exe_req = '{id: tid, rs1: a, rs2: b};
        ifu.exe_req = '{id: tid, rs1: a, rs2: b};
    endtask

    task automatic exe_issue(input logic [IdW-1:0] tid, input logic [31:0] a, input logic [31:0] b,
                             input bit with_dec, input logic [IdW-1:0] did, input logic [31:0] instr);
        check("exe_req_ready", 64'({ifs.exe_req_ready, ifu.exe_req_ready}), 64'(2'b11));
        exe_set(1'b1, tid, a, b);
        if (with_dec) dec_set(1'b1, did, instr);
        cycle();
        hs_cyc = cyc;
        exe_set(1'b0, '0, '0, '0);
        exp_s_q.push_back({tid, dot_ref(a, b, 1'b1)});
        exp_u_q.push_back({tid, dot_ref(a, b, 1'b0)});
        if (with_dec) begin
            dec_check(did, instr);
            dec_set(1'b0, '0, '0);
        end
    endtask

    task automatic exe_finish(input int hold);
        logic [IdW+31:0] exp_s;
        logic [IdW+31:0] exp_u;
        int guard;
        guard = 0;
        while (ifs.exe_rsp_valid !== 1'b1 && guard < 20) begin
            cycle();
            guard++;
        end
        check("exe_lat", 64'(cyc - hs_cyc), 64'(NumLanes));
        if (exp_s_q.size() == 0 || exp_u_q.size() == 0) begin
            check("exe_sb_empty", 64'(exp_s_q.size()), 64'(1));
            return;
        end
        exp_s = exp_s_q.pop_front();
        exp_u = exp_u_q.pop_front();
        check("exe_rsp_s", 64'({ifs.exe_rsp.id, ifs.exe_rsp.data}), 64'(exp_s));
        check("exe_rsp_u", 64'({ifu.exe_rsp_valid, ifu.exe_rsp.id, ifu.exe_rsp.data}), 64'({1'b1, exp_u}));
        check("exe_err", 64'({ifs.exe_rsp.err, ifu.exe_rsp.err}), 64'(0));
        for (int h = 0; h < hold; h++) begin
            cycle();
            check("exe_hold", 64'({ifs.exe_rsp_valid, ifs.exe_req_ready, ifs.exe_rsp.id, ifs.exe_rsp.data}),
                  64'({2'b10, exp_s}));
        end
        ifs.exe_rsp_ready = 1'b1;
        ifu.exe_rsp_ready = 1'b1;
        cycle();
        ifs.exe_rsp_ready = 1'b0;
        ifu.exe_rsp_ready = 1'b0;
        check("exe_after", 64'({ifs.exe_rsp_valid, ifs.exe_req_ready, ifu.exe_rsp_valid, ifu.exe_req_ready}),
              64'(4'b0101));
        check("exe_state_idle", 64'(ifs.dbg_state), 64'(ExeIdle));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        int seen;
        dec_set(1'b0, '0, '0);
        exe_set(1'b0, '0, '0, '0);
        ifs.dec_rsp_ready = 1'b1;
        ifu.dec_rsp_ready = 1'b1;
        ifs.exe_rsp_ready = 1'b0;
        ifu.exe_rsp_ready = 1'b0;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;

        check("rst_valids", 64'({ifs.dec_rsp_valid, ifs.exe_rsp_valid, ifu.dec_rsp_valid, ifu.exe_rsp_valid}), 64'(0));
        check("rst_readies", 64'({ifs.dec_req_ready, ifs.exe_req_ready, ifu.dec_req_ready, ifu.exe_req_ready}), 64'(4'hF));
        check("rst_payload", 64'({ifs.dec_rsp, ifs.exe_rsp}), 64'(0));
        check("rst_state", 64'(ifs.dbg_state), 64'(ExeIdle));

        // Decode accept then reject, back to back.
        dec_drive(4'd3, 32'h0020850B);
        dec_drive(4'd4, 32'h00208533);
        dec_stop();

        // Decode backpressure: response held and request side closed.
        ifs.dec_rsp_ready = 1'b0;
        ifu.dec_rsp_ready = 1'b0;
        dec_drive(4'd5, 32'h0000000B);
        dec_set(1'b0, '0, '0);
        for (int h = 0; h < 3; h++) begin
            cycle();
            check("dec_hold", 64'({ifs.dec_req_ready, ifs.dec_rsp_valid, ifs.dec_rsp.id, ifs.dec_rsp.accept}),
                  64'({2'b01, 4'd5, 1'b1}));
        end
        ifs.dec_rsp_ready = 1'b1;
        ifu.dec_rsp_ready = 1'b1;
        cycle();
        check("dec_release", 64'({ifs.dec_req_ready, ifs.dec_rsp_valid}), 64'(2'b10));

        // Directed execute vectors, backpressure, then a request 2 cycles later.
        exe_issue(4'd1, 32'h01020304, 32'h01010101, 1'b0, '0, '0);
        exe_finish(0);
        exe_issue(4'd2, 32'hFFFFFFFF, 32'h7F7F7F7F, 1'b0, '0, '0);
        exe_finish(0);
        exe_issue(4'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, '0, '0);
        exe_finish(10);
        repeat (2) cycle();
        exe_issue(4'd4, 32'h80807F01, 32'h807F8002, 1'b0, '0, '0);
        exe_finish(0);

        // Decode during BUSY, and simultaneous decode/execute handshakes.
        exe_issue(4'd6, 32'h12345678, 32'h9ABCDEF0, 1'b0, '0, '0);
        dec_drive(4'd7, 32'h0020850B);
        dec_stop();
        exe_finish(0);
        exe_issue(4'd8, 32'hDEADBEEF, 32'h0BADF00D, 1'b1, 4'd9, 32'h0030858B);
        exe_finish(1);

        // Reset mid-BUSY drops the operation.
        exe_issue(4'd10, 32'h01010101, 32'h01010101, 1'b0, '0, '0);
        cycle();
        rstn = 1'b0;
        cycle();
        rstn = 1'b1;
        exp_s_q.delete();
        exp_u_q.delete();
        check("rstb_readies", 64'({ifs.dec_req_ready, ifs.exe_req_ready, ifu.dec_req_ready, ifu.exe_req_ready}), 64'(4'hF));
        check("rstb_state", 64'(ifs.dbg_state), 64'(ExeIdle));
        seen = 0;
        for (int h = 0; h < 6; h++) begin
            cycle();
            if (ifs.exe_rsp_valid !== 1'b0 || ifu.exe_rsp_valid !== 1'b0) seen++;
        end
        check("rstb_no_rsp", 64'(seen), 64'(0));
        exe_issue(4'd11, 32'h7F807F80, 32'h7F7F8080, 1'b0, '0, '0);
        exe_finish(0);

        // Randomized mix.
        for (int t = 0; t < 24; t++) begin
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 4) == 0) a = 32'h80808080;
            if ($urandom_range(0, 4) == 0) b = 32'h7F80FF00;
            if ($urandom_range(0, 2) == 0)
                exe_issue(IdW'(t), a, b, 1'b1, IdW'(t + 5), rand_instr());
            else
                exe_issue(IdW'(t), a, b, 1'b0, '0, '0);
            if ($urandom_range(0, 1) == 0) begin
                dec_drive(IdW'(t + 1), rand_instr());
                dec_stop();
            end
            exe_finish($urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
